// File: rtl/mips_pkg.sv
// Shared MIPS definitions: exception causes, exception-unit FSM states,
// default handler-byte addresses and PC source mux selects.
package mips_pkg;

  typedef enum logic [1:0] {
    EXC_OPCODE   = 2'd0,
    EXC_OVERFLOW = 2'd1,
    EXC_DIVZERO  = 2'd2,
    EXC_RSVD     = 2'd3
  } exc_cause_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_LOAD = 2'd2,
    ST_DONE = 2'd3
  } evu_state_e;

  localparam int unsigned VEC_OPCODE_DEF   = 253;
  localparam int unsigned VEC_OVERFLOW_DEF = 254;
  localparam int unsigned VEC_DIVZERO_DEF  = 255;

  localparam logic [2:0] PCSRC_EPC = 3'd4;
  localparam logic [2:0] PCSRC_EXC = 3'd5;

  // Byte address of the handler byte for a given (non-reserved) cause.
  function automatic logic [31:0] vec_addr(input logic [1:0] cause,
                                           input int unsigned op,
                                           input int unsigned ov,
                                           input int unsigned dz);
    case (cause)
      EXC_OVERFLOW: return ov;
      EXC_DIVZERO:  return dz;
      default:      return op;
    endcase
  endfunction

endpackage

// File: rtl/exception_vector_unit_if.sv
// Memory read port of the exception vector unit.
interface exception_vector_unit_if;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_data_in;

  modport master (output mem_addr, output mem_rd, input mem_data_in);
  modport slave  (input mem_addr, input mem_rd, output mem_data_in);
endinterface

// File: rtl/exception_vector_unit_byte_lane_select.sv
// Picks one byte out of an aligned 32-bit word by byte offset (little-endian lanes).
module byte_lane_select (
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  output logic [7:0]  byte_out
);

  always_comb begin
    case (offset)
      2'd0:    byte_out = word[7:0];
      2'd1:    byte_out = word[15:8];
      2'd2:    byte_out = word[23:16];
      default: byte_out = word[31:24];
    endcase
  end

endmodule

// File: rtl/exception_vector_unit.sv
// Exception entry: captures EPC and cause, fetches the handler byte from the
// fixed vector location and strobes a PC load with the zero-extended target.
module exception_vector_unit
  import mips_pkg::*;
#(
  parameter int unsigned VEC_OPCODE   = VEC_OPCODE_DEF,
  parameter int unsigned VEC_OVERFLOW = VEC_OVERFLOW_DEF,
  parameter int unsigned VEC_DIVZERO  = VEC_DIVZERO_DEF,
  parameter int unsigned MEM_LATENCY  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          exc_req,
  input  logic [1:0]                    exc_cause,
  input  logic [31:0]                   pc_in,
  exception_vector_unit_if.master       mem,
  output logic [31:0]                   epc_out,
  output logic [31:0]                   exc_vector,
  output logic                          exc_pc_write,
  output logic [1:0]                    cause_out,
  output logic                          busy
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  evu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       epc_q, epc_d;
  logic [31:0]       vec_q, vec_d;
  logic [31:0]       addr_q, addr_d;
  logic [1:0]        cause_q, cause_d;
  logic              rd_q, rd_d;
  logic              strobe_q, strobe_d;
  logic              busy_q, busy_d;
  logic [7:0]        lane_byte;

  byte_lane_select u_lane (
    .word     (mem.mem_data_in),
    .offset   (addr_q[1:0]),
    .byte_out (lane_byte)
  );

  always_comb begin
    // NOTE: every _d starts as its _q so no branch can leave a signal unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    epc_d    = epc_q;
    vec_d    = vec_q;
    addr_d   = addr_q;
    cause_d  = cause_q;
    rd_d     = rd_q;
    strobe_d = strobe_q;
    busy_d   = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (exc_req && (exc_cause != EXC_RSVD)) begin
          state_d = ST_WAIT;
          epc_d   = pc_in - 32'd4;
          cause_d = exc_cause;
          addr_d  = vec_addr(exc_cause, VEC_OPCODE, VEC_OVERFLOW, VEC_DIVZERO);
          cnt_d   = CNT_W'(MEM_LATENCY);
          rd_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // Memory data is valid now; the target and strobe appear together next cycle.
        state_d  = ST_DONE;
        vec_d    = {24'b0, lane_byte};
        rd_d     = 1'b0;
        strobe_d = 1'b1;
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        strobe_d = 1'b0;
        busy_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every flop samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      epc_q    <= '0;
      vec_q    <= '0;
      addr_q   <= '0;
      cause_q  <= '0;
      rd_q     <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      epc_q    <= epc_d;
      vec_q    <= vec_d;
      addr_q   <= addr_d;
      cause_q  <= cause_d;
      rd_q     <= rd_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
    end
  end

  assign mem.mem_addr = addr_q;
  assign mem.mem_rd   = rd_q;
  assign epc_out      = epc_q;
  assign exc_vector   = vec_q;
  assign exc_pc_write = strobe_q;
  assign cause_out    = cause_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_exception_vector_unit.sv
// Two units (memory latency 1 and 3) share one stimulus stream; a cycle-count
// model predicts every output and literal checks pin the model.
module tb_exception_vector_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_req;
  logic [1:0]  exc_cause;
  logic [31:0] pc_in;
  logic [31:0] vec_word;

  logic [31:0] epc_o   [2];
  logic [31:0] vec_o   [2];
  logic [31:0] addr_o  [2];
  logic [31:0] mdata   [2];
  logic [1:0]  cause_o [2];
  logic        strobe_o[2];
  logic        busy_o  [2];
  logic        rd_o    [2];

  int n_cmp = 0;
  int n_err = 0;

  // Model state: cycles since acceptance (0 = idle) plus held outputs.
  int          mk     [2];
  logic [31:0] m_epc  [2];
  logic [31:0] m_vec  [2];
  logic [31:0] m_addr [2];
  logic [1:0]  m_cause[2];
  bit          started = 1'b0;
  int          rd_cnt [2];
  int          strobes[2];

  always #5 clk = ~clk;

  exception_vector_unit_if mif0 ();
  exception_vector_unit_if mif1 ();

  assign mif0.mem_data_in = mdata[0];
  assign mif1.mem_data_in = mdata[1];
  assign addr_o[0] = mif0.mem_addr;
  assign addr_o[1] = mif1.mem_addr;
  assign rd_o[0]   = mif0.mem_rd;
  assign rd_o[1]   = mif1.mem_rd;

  exception_vector_unit #(.MEM_LATENCY(1)) dut0 (
    .clk (clk), .reset (reset), .exc_req (exc_req), .exc_cause (exc_cause),
    .pc_in (pc_in), .mem (mif0), .epc_out (epc_o[0]), .exc_vector (vec_o[0]),
    .exc_pc_write (strobe_o[0]), .cause_out (cause_o[0]), .busy (busy_o[0])
  );

  exception_vector_unit #(.MEM_LATENCY(3)) dut1 (
    .clk (clk), .reset (reset), .exc_req (exc_req), .exc_cause (exc_cause),
    .pc_in (pc_in), .mem (mif1), .epc_out (epc_o[1]), .exc_vector (vec_o[1]),
    .exc_pc_write (strobe_o[1]), .cause_out (cause_o[1]), .busy (busy_o[1])
  );

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [1:0] c, input logic [31:0] pc);
    exc_req   = 1'b1;
    exc_cause = c;
    pc_in     = pc;
    tick();
    exc_req   = 1'b0;
  endtask

  // Behavioural model: an accepted request walks through L+2 busy cycles.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        mk[d]      <= 0;
        m_epc[d]   <= '0;
        m_vec[d]   <= '0;
        m_addr[d]  <= '0;
        m_cause[d] <= '0;
      end else if (mk[d] == 0) begin
        if (exc_req && exc_cause != 2'd3) begin
          mk[d]      <= 1;
          m_epc[d]   <= pc_in - 32'd4;
          m_cause[d] <= exc_cause;
          m_addr[d]  <= 32'd253 + 32'(exc_cause);
        end
      end else begin
        if (mk[d] == lat(d) + 1)
          m_vec[d] <= (vec_word >> (8 * (m_addr[d] % 4))) & 32'h0000_00FF;
        mk[d] <= (mk[d] == lat(d) + 2) ? 0 : mk[d] + 1;
      end
    end
    started <= 1'b1;
  end

  // Memory: valid word only on the cycle L after the first read cycle, garbage otherwise.
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      rd_cnt[d] = (rd_o[d] === 1'b1) ? rd_cnt[d] + 1 : 0;
      mdata[d]  = (rd_cnt[d] == lat(d) + 1) ? vec_word : ~vec_word;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("d%0d busy", d),   32'(busy_o[d]),   32'(mk[d] != 0));
        check($sformatf("d%0d mem_rd", d), 32'(rd_o[d]),     32'(mk[d] >= 1 && mk[d] <= lat(d) + 1));
        check($sformatf("d%0d strobe", d), 32'(strobe_o[d]), 32'(mk[d] == lat(d) + 2));
        check($sformatf("d%0d epc", d),    epc_o[d],         m_epc[d]);
        check($sformatf("d%0d vector", d), vec_o[d],         m_vec[d]);
        check($sformatf("d%0d addr", d),   addr_o[d],        m_addr[d]);
        check($sformatf("d%0d cause", d),  32'(cause_o[d]),  32'(m_cause[d]));
        if (strobe_o[d] === 1'b1) strobes[d] <= strobes[d] + 1;
      end
    end
  end

  initial begin
    int base[2];
    logic [1:0]  tc [2];
    logic [31:0] tv [2];
    logic [31:0] ta [2];
    strobes[0] = 0; strobes[1] = 0;
    rd_cnt[0] = 0;  rd_cnt[1] = 0;
    mdata[0] = '0;  mdata[1] = '0;
    reset = 1'b1; exc_req = 1'b0; exc_cause = 2'd0; pc_in = '0;
    vec_word = 32'h4433_2211;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d reset busy", d), 32'(busy_o[d]), 32'd0);
      check($sformatf("d%0d reset epc", d),  epc_o[d],        32'd0);
      check($sformatf("d%0d reset vec", d),  vec_o[d],        32'd0);
      check($sformatf("d%0d reset addr", d), addr_o[d],       32'd0);
    end
    reset = 1'b0;
    tick();

    // Overflow, pc 0x104.
    request(2'd1, 32'h0000_0104);                     // cycle 1
    check("d0 c1 mem_rd", 32'(rd_o[0]), 32'd1);
    check("d0 c1 addr", addr_o[0], 32'd254);
    tick();                                           // cycle 2
    check("d0 c2 mem_rd", 32'(rd_o[0]), 32'd1);
    tick();                                           // cycle 3
    check("d0 c3 strobe", 32'(strobe_o[0]), 32'd1);
    check("d0 c3 mem_rd", 32'(rd_o[0]), 32'd0);
    check("d0 c3 vector", vec_o[0], 32'h0000_0033);
    check("d0 c3 epc", epc_o[0], 32'h0000_0100);
    tick();                                           // cycle 4
    check("d0 c4 busy", 32'(busy_o[0]), 32'd0);
    check("d1 c4 mem_rd", 32'(rd_o[1]), 32'd1);
    tick();                                           // cycle 5
    check("d1 c5 strobe", 32'(strobe_o[1]), 32'd1);
    check("d1 c5 vector", vec_o[1], 32'h0000_0033);
    tick();                                           // cycle 6
    check("d1 c6 busy", 32'(busy_o[1]), 32'd0);

    // Opcode and divide-by-zero from the same word.
    tc[0] = 2'd0; tv[0] = 32'h22; ta[0] = 32'd253;
    tc[1] = 2'd2; tv[1] = 32'h44; ta[1] = 32'd255;
    for (int i = 0; i < 2; i++) begin
      request(tc[i], 32'h0000_0104);
      repeat (6) tick();
      for (int d = 0; d < 2; d++) begin
        check($sformatf("d%0d cause%0d vector", d, tc[i]), vec_o[d], tv[i]);
        check($sformatf("d%0d cause%0d addr", d, tc[i]), addr_o[d], ta[i]);
      end
    end

    // Reserved cause is ignored.
    request(2'd3, 32'h0000_0555);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d rsvd busy", d), 32'(busy_o[d]), 32'd0);
      check($sformatf("d%0d rsvd epc", d),  epc_o[d],       32'h0000_0100);
    end
    tick();

    // Second request during an active fetch is dropped.
    base[0] = strobes[0]; base[1] = strobes[1];
    request(2'd1, 32'h0000_0200);                     // cycle 1
    tick();                                           // cycle 2
    request(2'd0, 32'h0000_0900);                     // sampled at end of cycle 2
    repeat (4) tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d overlap strobes", d), 32'(strobes[d] - base[d]), 32'd1);
      check($sformatf("d%0d overlap epc", d),     epc_o[d],                  32'h0000_01FC);
      check($sformatf("d%0d overlap cause", d),   32'(cause_o[d]),           32'd1);
    end

    // Reset in the middle of WAIT.
    base[0] = strobes[0]; base[1] = strobes[1];
    request(2'd2, 32'h0000_0300);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d midrst busy", d),   32'(busy_o[d]),   32'd0);
      check($sformatf("d%0d midrst rd", d),     32'(rd_o[d]),     32'd0);
      check($sformatf("d%0d midrst strobe", d), 32'(strobe_o[d]), 32'd0);
      check($sformatf("d%0d midrst epc", d),    epc_o[d],         32'd0);
      check($sformatf("d%0d midrst vec", d),    vec_o[d],         32'd0);
      check($sformatf("d%0d midrst addr", d),   addr_o[d],        32'd0);
      check($sformatf("d%0d midrst cause", d),  32'(cause_o[d]),  32'd0);
    end
    repeat (6) tick();
    for (int d = 0; d < 2; d++)
      check($sformatf("d%0d midrst strobes", d), 32'(strobes[d] - base[d]), 32'd0);

    // Fresh request after reset, with PC wrap.
    request(2'd1, 32'h0000_0000);
    repeat (5) tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d wrap epc", d),    epc_o[d], 32'hFFFF_FFFC);
      check($sformatf("d%0d wrap vector", d), vec_o[d], 32'h0000_0033);
    end

    // Randomised traffic.
    repeat (3000) begin
      exc_req   = ($urandom_range(0, 3) == 0);
      exc_cause = 2'($urandom_range(0, 3));
      pc_in     = $urandom;
      reset     = ($urandom_range(0, 99) == 0);
      if (mk[0] == 0 && mk[1] == 0 && $urandom_range(0, 9) == 0) vec_word = $urandom;
      tick();
    end
    reset   = 1'b0;
    exc_req = 1'b0;
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
